mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter ACK_TIMEOUT, default 64, SHALL set the maximum number of REQ cycles waited for Dmem_Ack (range 1..255).
REQ-002 Clk  in  1  single clock SHALL be the only clock; all state changes on its rising edge.
REQ-003 Reset_n  in  1  reset SHALL be asynchronous and active-low.
REQ-004 MemRead_MEM  in  1  load request from the EX/MEM register.
REQ-005 MemWrite_MEM  in  1  store request from the EX/MEM register.
REQ-006 Mem_Size_MEM  in  2  access size: 00 byte, 01 half, 10 word; 11 SHALL be treated as word.
REQ-007 Mem_Unsigned_MEM  in  1  1 = zero-extend, 0 = sign-extend byte/half loads.
REQ-008 ALU_Result_MEM  in  32  effective byte address.
REQ-009 Write_Data_MEM  in  32  store data, right-aligned.
REQ-010 Read_Data_MEM  out  32  formatted load data, consumed by the MEM/WB register.
REQ-011 Stall_MEM  out  1  freeze PC and all upstream pipeline registers.
REQ-012 Dmem_Req, Dmem_We  out  1 each  bus request and write strobe.
REQ-013 Dmem_Addr  out  32; Dmem_Wdata  out  32; Dmem_Be  out  4  bus address (word-aligned), data, byte enables.
REQ-014 Dmem_Ack  in  1; Dmem_Rdata  in  32  bus completion and read data.
REQ-015 Bus_Error  out  1; Misalign_MEM  out  1  one-cycle error pulses.

Function
REQ-016 FSM states: IDLE, REQ, DONE; access = MemRead_MEM | MemWrite_MEM.
REQ-017 IDLE: with access, Stall_MEM = 1 combinationally and next state = REQ; without access, Stall_MEM = 0 and Read_Data_MEM = 0.
REQ-018 REQ: Dmem_Req, Dmem_We, Dmem_Addr, Dmem_Be, Dmem_Wdata driven from registers captured on the IDLE->REQ edge; Stall_MEM = 1.
REQ-019 REQ: Dmem_Ack sampled high -> capture Dmem_Rdata and go to DONE; minimum access latency is 3 cycles (IDLE, REQ, DONE).
REQ-020 REQ: 8-bit wait counter reaching ACK_TIMEOUT without Ack -> DONE, Bus_Error = 1 for the DONE cycle, and captured data = 0.
REQ-021 DONE: Stall_MEM = 0, Dmem_Req = 0, Read_Data_MEM = formatted captured data (0 for stores); unconditional transition to IDLE.
REQ-022 Addressing is little-endian. Byte Be = 0001 << addr[1:0]; half Be = 0011 << (2*addr[1]); word Be = 1111.
REQ-023 Store data is replicated: byte to all 4 lanes, half to both halves.
REQ-024 Loads extract the addressed lane and extend per Mem_Unsigned_MEM (e.g. byte 0x80 -> 0xFFFFFF80 signed, 0x00000080 unsigned).
REQ-025 MemRead_MEM and MemWrite_MEM both set: SHALL be performed as a store; Read_Data_MEM = 0.
REQ-026 Upstream inputs may change during REQ; only the captured registers drive the bus.

Reset
REQ-027 Reset_n low SHALL immediately force state IDLE, the counter to 0, Dmem_Req/Dmem_We/Dmem_Be/Dmem_Addr/Dmem_Wdata to 0, captured data to 0, and Bus_Error/Misalign_MEM to 0.
REQ-028 Reset during REQ SHALL abandon the bus transaction; a late Dmem_Ack after release SHALL be ignored in IDLE.

Configuration
REQ-029 Macro MEM_ALIGN_CHECK_EN defined: half with addr[0] = 1, or word with addr[1:0] != 0, SHALL issue no request, keep Stall_MEM = 0, pulse Misalign_MEM for that cycle, and return Read_Data_MEM = 0.
REQ-030 Macro undefined: Misalign_MEM is tied 0, and the misaligned low address bits are ignored (half uses addr[1]; word ignores addr[1:0]).

Structure
REQ-031 Shared package mips_mem_pkg SHALL hold the size encodings, the FSM state enum and the default ACK_TIMEOUT.
REQ-032 Lane extract/extend logic SHALL be the sub-module mem_load_align, which is combinational and reusable.

Verification
REQ-033 Load word at 0x100, Rdata = 0xDEADBEEF, Ack in first REQ cycle -> Stall high 2 cycles, Read_Data_MEM = 0xDEADBEEF in DONE.
REQ-034 Signed byte load at 0x103, Rdata = 0x80123456 -> Be = 1000, Read_Data_MEM = 0xFFFFFF80; unsigned -> 0x00000080.
REQ-035 Store half 0x1234 at 0x202 -> Dmem_We = 1, Be = 1100, Wdata = 0x12341234, Read_Data_MEM = 0.
REQ-036 No Ack with ACK_TIMEOUT = 4 -> DONE after 4 REQ cycles, Bus_Error pulse, Read_Data_MEM = 0.
REQ-037 Reset_n low in the 2nd REQ cycle -> Dmem_Req = 0 with no clock edge; Ack after release is ignored and the FSM stays in IDLE.
REQ-038 With MEM_ALIGN_CHECK_EN, load word at 0x101 -> no Dmem_Req, Misalign_MEM = 1 for one cycle, Stall_MEM = 0.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// -----------------------------------------------------------------------------
// mips_mem_pkg
// Shared definitions for the MEM stage data-memory path:
//   - access size encodings (Mem_Size_MEM)
//   - FSM state enum of mem_access_stage
//   - default Dmem_Ack timeout
//   - helpers for byte enables, store lane replication and alignment test
// -----------------------------------------------------------------------------
package mips_mem_pkg;

  localparam logic [1:0] SIZE_BYTE     = 2'b00;
  localparam logic [1:0] SIZE_HALF     = 2'b01;
  localparam logic [1:0] SIZE_WORD     = 2'b10;
  localparam logic [1:0] SIZE_WORD_ALT = 2'b11;  // decoded as a word access

  localparam int unsigned ACK_TIMEOUT_DEFAULT = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  // Little-endian byte enables. A half access selects its half with addr[1]
  // only, so a set addr[0] is ignored here.
  function automatic logic [3:0] byte_enables(input logic [1:0] size,
                                              input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      SIZE_BYTE: be = 4'b0001 << addr_lo;
      SIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

  // Right-aligned store data is replicated across all lanes so the byte
  // enables alone select what the memory writes.
  function automatic logic [31:0] store_lanes(input logic [1:0]  size,
                                              input logic [31:0] wdata);
    logic [31:0] lanes;
    case (size)
      SIZE_BYTE: lanes = {4{wdata[7:0]}};
      SIZE_HALF: lanes = {2{wdata[15:0]}};
      default:   lanes = wdata;
    endcase
    return lanes;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = addr_lo[0];
      default:   mis = |addr_lo;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// -----------------------------------------------------------------------------
// mem_load_align
// Combinational load formatter: picks the addressed byte/half lane out of a
// 32-bit bus word and sign- or zero-extends it to 32 bits. Word accesses
// (size 10 or 11) pass the bus word through unchanged.
//
// Ports
//   rdata     in  32  raw little-endian bus word
//   addr_lo   in   2  low address bits of the access
//   size      in   2  access size (mips_mem_pkg SIZE_*)
//   zero_ext  in   1  1 = zero-extend, 0 = sign-extend
//   data      out 32  formatted load result
// -----------------------------------------------------------------------------
module mem_load_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        zero_ext,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        ext_b;
  logic        ext_h;

  always_comb begin
    case (addr_lo)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    // addr[0] is ignored for halves; misaligned halves never reach here when
    // alignment checking is built in.
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    ext_b = ~zero_ext & lane_b[7];
    ext_h = ~zero_ext & lane_h[15];

    case (size)
      SIZE_BYTE: data = {{24{ext_b}}, lane_b};
      SIZE_HALF: data = {{16{ext_h}}, lane_h};
      default:   data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// MEM pipeline stage of a MIPS-style core. Turns a load/store request from the
// EX/MEM register into a single bus transaction (IDLE -> REQ -> DONE), stalls
// the upstream pipeline while the bus is busy, and formats load data for the
// MEM/WB register.
//
// Build option: define MEM_ALIGN_CHECK_EN to reject misaligned half/word
// accesses (no bus request, one-cycle Misalign_MEM pulse). Without it the
// misaligned low address bits are ignored and Misalign_MEM is tied low.
//
// Parameters
//   ACK_TIMEOUT       REQ cycles waited for Dmem_Ack before Bus_Error (1..255)
//
// Ports
//   Clk               in   1  clock, rising edge
//   Reset_n           in   1  asynchronous active-low reset
//   MemRead_MEM       in   1  load request
//   MemWrite_MEM      in   1  store request (wins if both set)
//   Mem_Size_MEM      in   2  00 byte, 01 half, 10/11 word
//   Mem_Unsigned_MEM  in   1  zero-extend byte/half loads
//   ALU_Result_MEM    in  32  effective byte address
//   Write_Data_MEM    in  32  right-aligned store data
//   Read_Data_MEM     out 32  formatted load data (valid in DONE)
//   Stall_MEM         out  1  freeze PC and upstream registers
//   Dmem_Req          out  1  bus request
//   Dmem_We           out  1  bus write strobe
//   Dmem_Addr         out 32  word-aligned bus address
//   Dmem_Wdata        out 32  lane-replicated store data
//   Dmem_Be           out  4  byte enables
//   Dmem_Ack          in   1  bus completion
//   Dmem_Rdata        in  32  bus read data
//   Bus_Error         out  1  one-cycle pulse on Ack timeout
//   Misalign_MEM      out  1  one-cycle pulse on rejected misaligned access
// -----------------------------------------------------------------------------
module mem_access_stage
  import mips_mem_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
)(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        MemRead_MEM,
  input  logic        MemWrite_MEM,
  input  logic [1:0]  Mem_Size_MEM,
  input  logic        Mem_Unsigned_MEM,
  input  logic [31:0] ALU_Result_MEM,
  input  logic [31:0] Write_Data_MEM,
  output logic [31:0] Read_Data_MEM,
  output logic        Stall_MEM,
  output logic        Dmem_Req,
  output logic        Dmem_We,
  output logic [31:0] Dmem_Addr,
  output logic [31:0] Dmem_Wdata,
  output logic [3:0]  Dmem_Be,
  input  logic        Dmem_Ack,
  input  logic [31:0] Dmem_Rdata,
  output logic        Bus_Error,
  output logic        Misalign_MEM
);

  // Last wait-counter value before the timeout fires (counter starts at 0 in
  // the first REQ cycle, so ACK_TIMEOUT REQ cycles are granted).
  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

  mem_state_e  state;
  logic [7:0]  wait_cnt;

  // Access attributes captured on the IDLE->REQ edge; upstream may change
  // while the transaction is in flight.
  logic        load_q;
  logic [1:0]  size_q;
  logic [1:0]  addr_lo_q;
  logic        zext_q;
  logic [31:0] rdata_q;

  logic        access;
  logic        misalign;
  logic        start;
  logic [31:0] load_fmt;

  assign access = MemRead_MEM | MemWrite_MEM;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign     = access & is_misaligned(Mem_Size_MEM, ALU_Result_MEM[1:0]);
  // Flags the instruction currently presented, so it is combinational; reset
  // masks it because the FSM may be forced to IDLE with a request pending.
  assign Misalign_MEM = (state == ST_IDLE) & misalign & Reset_n;
`else
  assign misalign     = 1'b0;
  assign Misalign_MEM = 1'b0;
`endif

  assign start     = (state == ST_IDLE) & access & ~misalign;
  assign Stall_MEM = start | (state == ST_REQ);

  // FSM and bus registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= ST_IDLE;
      wait_cnt   <= 8'd0;
      Dmem_Req   <= 1'b0;
      Dmem_We    <= 1'b0;
      Dmem_Addr  <= 32'd0;
      Dmem_Wdata <= 32'd0;
      Dmem_Be    <= 4'd0;
      Bus_Error  <= 1'b0;
      load_q     <= 1'b0;
      size_q     <= SIZE_BYTE;
      addr_lo_q  <= 2'd0;
      zext_q     <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      Bus_Error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_REQ;
            wait_cnt   <= 8'd0;
            Dmem_Req   <= 1'b1;
            Dmem_We    <= MemWrite_MEM;
            Dmem_Addr  <= {ALU_Result_MEM[31:2], 2'b00};
            Dmem_Be    <= byte_enables(Mem_Size_MEM, ALU_Result_MEM[1:0]);
            Dmem_Wdata <= store_lanes(Mem_Size_MEM, Write_Data_MEM);
            // Read and write together is performed as a store.
            load_q     <= MemRead_MEM & ~MemWrite_MEM;
            size_q     <= Mem_Size_MEM;
            addr_lo_q  <= ALU_Result_MEM[1:0];
            zext_q     <= Mem_Unsigned_MEM;
            rdata_q    <= 32'd0;
          end
        end

        ST_REQ: begin
          if (Dmem_Ack) begin
            state    <= ST_DONE;
            Dmem_Req <= 1'b0;
            Dmem_We  <= 1'b0;
            rdata_q  <= load_q ? Dmem_Rdata : 32'd0;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            state     <= ST_DONE;
            Dmem_Req  <= 1'b0;
            Dmem_We   <= 1'b0;
            rdata_q   <= 32'd0;
            Bus_Error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  mem_load_align u_load_align (
    .rdata    (rdata_q),
    .addr_lo  (addr_lo_q),
    .size     (size_q),
    .zero_ext (zext_q),
    .data     (load_fmt)
  );

  // Stores and timeouts capture zero, so DONE needs no further qualification.
  assign Read_Data_MEM = (state == ST_DONE) ? load_fmt : 32'd0;

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
// Directed bench for mem_access_stage (ACK_TIMEOUT = 4): a table of single
// accesses with hand-computed bus fields and load results, followed by hand
// sequences for reset during a transaction and (when MEM_ALIGN_CHECK_EN is
// defined) misalignment rejection.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        Clk;
  logic        Reset_n;
  logic        MemRead_MEM;
  logic        MemWrite_MEM;
  logic [1:0]  Mem_Size_MEM;
  logic        Mem_Unsigned_MEM;
  logic [31:0] ALU_Result_MEM;
  logic [31:0] Write_Data_MEM;
  logic [31:0] Read_Data_MEM;
  logic        Stall_MEM;
  logic        Dmem_Req;
  logic        Dmem_We;
  logic [31:0] Dmem_Addr;
  logic [31:0] Dmem_Wdata;
  logic [3:0]  Dmem_Be;
  logic        Dmem_Ack;
  logic [31:0] Dmem_Rdata;
  logic        Bus_Error;
  logic        Misalign_MEM;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_stage #(.ACK_TIMEOUT(TO)) dut (
    .Clk              (Clk),
    .Reset_n          (Reset_n),
    .MemRead_MEM      (MemRead_MEM),
    .MemWrite_MEM     (MemWrite_MEM),
    .Mem_Size_MEM     (Mem_Size_MEM),
    .Mem_Unsigned_MEM (Mem_Unsigned_MEM),
    .ALU_Result_MEM   (ALU_Result_MEM),
    .Write_Data_MEM   (Write_Data_MEM),
    .Read_Data_MEM    (Read_Data_MEM),
    .Stall_MEM        (Stall_MEM),
    .Dmem_Req         (Dmem_Req),
    .Dmem_We          (Dmem_We),
    .Dmem_Addr        (Dmem_Addr),
    .Dmem_Wdata       (Dmem_Wdata),
    .Dmem_Be          (Dmem_Be),
    .Dmem_Ack         (Dmem_Ack),
    .Dmem_Rdata       (Dmem_Rdata),
    .Bus_Error        (Bus_Error),
    .Misalign_MEM     (Misalign_MEM)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Global time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        zext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_dly;   // REQ cycle index carrying Ack, -1 = never
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rd;
    logic        exp_berr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] size,
                              input logic zext, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int ack_dly, input logic exp_we,
                              input logic [31:0] exp_addr, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata, input logic [31:0] exp_rd,
                              input logic exp_berr);
    vec_t v;
    v.rd = rd; v.wr = wr; v.size = size; v.zext = zext; v.addr = addr;
    v.wdata = wdata; v.rdata = rdata; v.ack_dly = ack_dly; v.exp_we = exp_we;
    v.exp_addr = exp_addr; v.exp_be = exp_be; v.exp_wdata = exp_wdata;
    v.exp_rd = exp_rd; v.exp_berr = exp_berr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    MemRead_MEM      = 1'b0;
    MemWrite_MEM     = 1'b0;
    Mem_Size_MEM     = 2'b00;
    Mem_Unsigned_MEM = 1'b0;
    ALU_Result_MEM   = 32'd0;
    Write_Data_MEM   = 32'd0;
  endtask

  // Called just after a rising edge with the FSM in IDLE; returns the same way.
  task automatic run_vec(input int idx, input vec_t v);
    int    stall_cnt;
    int    n_req;
    string p;
    p = $sformatf("v%0d", idx);
    n_req = (v.ack_dly >= 0) ? v.ack_dly + 1 : TO;
    stall_cnt = 0;

    MemRead_MEM      = v.rd;
    MemWrite_MEM     = v.wr;
    Mem_Size_MEM     = v.size;
    Mem_Unsigned_MEM = v.zext;
    ALU_Result_MEM   = v.addr;
    Write_Data_MEM   = v.wdata;
    Dmem_Ack         = 1'b0;
    Dmem_Rdata       = 32'hFFFF_FFFF;

    @(negedge Clk);
    chk({p, "_idle_stall"}, 32'(Stall_MEM), 32'd1);
    chk({p, "_idle_req"}, 32'(Dmem_Req), 32'd0);
    chk({p, "_idle_misalign"}, 32'(Misalign_MEM), 32'd0);
    stall_cnt += int'(Stall_MEM);
    @(posedge Clk); #1;

    // Upstream moves on while the bus is busy; only captured values count.
    ALU_Result_MEM   = ~v.addr;
    Write_Data_MEM   = ~v.wdata;
    Mem_Size_MEM     = ~v.size;
    Mem_Unsigned_MEM = ~v.zext;

    for (int c = 0; c < n_req; c++) begin
      Dmem_Ack   = (c == v.ack_dly);
      Dmem_Rdata = (c == v.ack_dly) ? v.rdata : (32'h5A5A_5A5A ^ 32'(c));
      @(negedge Clk);
      stall_cnt += int'(Stall_MEM);
      chk($sformatf("%s_req%0d_req", p, c), 32'(Dmem_Req), 32'd1);
      if (c == 0) begin
        chk({p, "_we"},    32'(Dmem_We), 32'(v.exp_we));
        chk({p, "_addr"},  Dmem_Addr,    v.exp_addr);
        chk({p, "_be"},    32'(Dmem_Be), 32'(v.exp_be));
        chk({p, "_wdata"}, Dmem_Wdata,   v.exp_wdata);
        chk({p, "_req_rd"}, Read_Data_MEM, 32'd0);
      end
      @(posedge Clk); #1;
    end
    Dmem_Ack     = 1'b0;
    Dmem_Rdata   = 32'hFFFF_FFFF;
    MemRead_MEM  = 1'b0;
    MemWrite_MEM = 1'b0;

    @(negedge Clk);
    chk({p, "_done_stall"}, 32'(Stall_MEM), 32'd0);
    chk({p, "_done_req"},   32'(Dmem_Req), 32'd0);
    chk({p, "_done_rd"},    Read_Data_MEM, v.exp_rd);
    chk({p, "_done_berr"},  32'(Bus_Error), 32'(v.exp_berr));
    chk({p, "_stall_cycles"}, 32'(stall_cnt), 32'(1 + n_req));

    @(posedge Clk); #1;
    chk({p, "_after_rd"},    Read_Data_MEM, 32'd0);
    chk({p, "_after_stall"}, 32'(Stall_MEM), 32'd0);
    chk({p, "_after_berr"},  32'(Bus_Error), 32'd0);
    chk({p, "_after_req"},   32'(Dmem_Req), 32'd0);
  endtask

  initial begin
    Reset_n    = 1'b0;
    Dmem_Ack   = 1'b0;
    Dmem_Rdata = 32'd0;
    clear_inputs();

    //          rd wr size  zx addr          wdata         rdata         ack we  exp_addr      be       exp_wdata     exp_rd        berr
    vecs.push_back(mk(1, 0, 2'b10, 0, 32'h0000_0100, 32'h0000_0000, 32'hDEAD_BEEF, 0, 0, 32'h0000_0100, 4'b1111, 32'h0000_0000, 32'hDEAD_BEEF, 0));
    vecs.push_back(mk(1, 0, 2'b00, 0, 32'h0000_0103, 32'h0000_0000, 32'h8012_3456, 0, 0, 32'h0000_0100, 4'b1000, 32'h0000_0000, 32'hFFFF_FF80, 0));
    vecs.push_back(mk(1, 0, 2'b00, 1, 32'h0000_0103, 32'h0000_0000, 32'h8012_3456, 0, 0, 32'h0000_0100, 4'b1000, 32'h0000_0000, 32'h0000_0080, 0));
    vecs.push_back(mk(0, 1, 2'b01, 0, 32'h0000_0202, 32'hABCD_1234, 32'hFFFF_FFFF, 1, 1, 32'h0000_0200, 4'b1100, 32'h1234_1234, 32'h0000_0000, 0));
    vecs.push_back(mk(1, 0, 2'b01, 0, 32'h0000_0102, 32'h0000_0000, 32'h8001_7FFF, 2, 0, 32'h0000_0100, 4'b1100, 32'h0000_0000, 32'hFFFF_8001, 0));
    vecs.push_back(mk(1, 0, 2'b01, 1, 32'h0000_0100, 32'h0000_0000, 32'h8001_F00D, 0, 0, 32'h0000_0100, 4'b0011, 32'h0000_0000, 32'h0000_F00D, 0));
    vecs.push_back(mk(0, 1, 2'b00, 0, 32'h0000_0301, 32'h1234_56A5, 32'hFFFF_FFFF, 0, 1, 32'h0000_0300, 4'b0010, 32'hA5A5_A5A5, 32'h0000_0000, 0));
    vecs.push_back(mk(0, 1, 2'b10, 0, 32'h0000_0404, 32'hCAFE_F00D, 32'hFFFF_FFFF, 3, 1, 32'h0000_0404, 4'b1111, 32'hCAFE_F00D, 32'h0000_0000, 0));
    vecs.push_back(mk(1, 1, 2'b10, 0, 32'h0000_0500, 32'h1122_3344, 32'h9999_9999, 0, 1, 32'h0000_0500, 4'b1111, 32'h1122_3344, 32'h0000_0000, 0));
    vecs.push_back(mk(1, 0, 2'b11, 0, 32'h0000_0600, 32'h0000_0000, 32'h8765_4321, 0, 0, 32'h0000_0600, 4'b1111, 32'h0000_0000, 32'h8765_4321, 0));
    vecs.push_back(mk(1, 0, 2'b10, 0, 32'h0000_0700, 32'h0000_0000, 32'h1234_5678, -1, 0, 32'h0000_0700, 4'b1111, 32'h0000_0000, 32'h0000_0000, 1));
    vecs.push_back(mk(1, 0, 2'b00, 0, 32'h0000_0001, 32'h0000_0000, 32'h0000_7F00, 0, 0, 32'h0000_0000, 4'b0010, 32'h0000_0000, 32'h0000_007F, 0));
`ifndef MEM_ALIGN_CHECK_EN
    // Without alignment checking the stray low address bits are ignored.
    vecs.push_back(mk(1, 0, 2'b10, 0, 32'h0000_0101, 32'h0000_0000, 32'h0BAD_F00D, 0, 0, 32'h0000_0100, 4'b1111, 32'h0000_0000, 32'h0BAD_F00D, 0));
    vecs.push_back(mk(1, 0, 2'b01, 0, 32'h0000_0103, 32'h0000_0000, 32'hC0DE_1234, 0, 0, 32'h0000_0100, 4'b1100, 32'h0000_0000, 32'hFFFF_C0DE, 0));
`endif

    // Reset state, held through one rising edge.
    @(posedge Clk); #1;
    chk("rst_req",    32'(Dmem_Req), 32'd0);
    chk("rst_we",     32'(Dmem_We), 32'd0);
    chk("rst_be",     32'(Dmem_Be), 32'd0);
    chk("rst_addr",   Dmem_Addr, 32'd0);
    chk("rst_wdata",  Dmem_Wdata, 32'd0);
    chk("rst_berr",   32'(Bus_Error), 32'd0);
    chk("rst_mis",    32'(Misalign_MEM), 32'd0);
    chk("rst_stall",  32'(Stall_MEM), 32'd0);
    chk("rst_rd",     Read_Data_MEM, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(i, vecs[i]);
    end

    // Reset asserted in the second REQ cycle abandons the transaction.
    MemRead_MEM    = 1'b1;
    Mem_Size_MEM   = 2'b10;
    ALU_Result_MEM = 32'h0000_0800;
    @(posedge Clk); #1;              // REQ cycle 0
    @(posedge Clk); #1;              // REQ cycle 1
    chk("rstreq_req_before", 32'(Dmem_Req), 32'd1);
    #2;
    Reset_n = 1'b0;
    clear_inputs();
    #1;
    chk("rstreq_req_async",  32'(Dmem_Req), 32'd0);
    chk("rstreq_addr_async", Dmem_Addr, 32'd0);
    chk("rstreq_be_async",   32'(Dmem_Be), 32'd0);
    chk("rstreq_stall",      32'(Stall_MEM), 32'd0);
    @(negedge Clk); #1;
    Reset_n    = 1'b1;
    Dmem_Ack   = 1'b1;
    Dmem_Rdata = 32'h1111_1111;
    for (int k = 0; k < 2; k++) begin
      @(negedge Clk);
      chk($sformatf("lateack%0d_req", k),   32'(Dmem_Req), 32'd0);
      chk($sformatf("lateack%0d_stall", k), 32'(Stall_MEM), 32'd0);
      chk($sformatf("lateack%0d_rd", k),    Read_Data_MEM, 32'd0);
      chk($sformatf("lateack%0d_berr", k),  32'(Bus_Error), 32'd0);
    end
    Dmem_Ack = 1'b0;
    @(posedge Clk); #1;

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned word load: rejected without a bus request.
    MemRead_MEM    = 1'b1;
    Mem_Size_MEM   = 2'b10;
    ALU_Result_MEM = 32'h0000_0101;
    #1;
    chk("mis_w_flag",  32'(Misalign_MEM), 32'd1);
    chk("mis_w_stall", 32'(Stall_MEM), 32'd0);
    chk("mis_w_req",   32'(Dmem_Req), 32'd0);
    chk("mis_w_rd",    Read_Data_MEM, 32'd0);
    @(posedge Clk); #1;
    clear_inputs();
    #1;
    chk("mis_w_req_after", 32'(Dmem_Req), 32'd0);
    chk("mis_w_flag_after", 32'(Misalign_MEM), 32'd0);
    // Misaligned half store: no write reaches the bus.
    MemWrite_MEM   = 1'b1;
    Mem_Size_MEM   = 2'b01;
    ALU_Result_MEM = 32'h0000_0203;
    #1;
    chk("mis_h_flag",  32'(Misalign_MEM), 32'd1);
    chk("mis_h_stall", 32'(Stall_MEM), 32'd0);
    @(posedge Clk); #1;
    clear_inputs();
    #1;
    chk("mis_h_we_after",  32'(Dmem_We), 32'd0);
    chk("mis_h_req_after", 32'(Dmem_Req), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
